// File: rtl/voxel_world_gen.sv
// ---------------------------------------------------------------------------
// voxel_world_gen
//   Procedural voxel world builder. After an accepted start request it sweeps
//   every cell of a GRID_SIZE^3 volume (x fastest, then y, then z) and emits
//   one 64-bit voxel write per clock. The terrain is a deterministic mix of
//   bedrock, stone, grass, water and air. The completion flag stays high after
//   the sweep so frame sequencing can gate on it.
//
// Handshake: start is level-sampled and is accepted only in IDLE. While busy
//   is high, write_en is high on every cycle, with no gaps, and write_addr and
//   write_data are valid whenever write_en is high. The memory side has no
//   back-pressure.
//
// Ports:
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   start       in   start request, accepted only when not busy
//   busy        out  high while the sweep is in progress
//   done        out  sticky completion flag; cleared by the next accepted start
//   write_addr  out  voxel write address = z*G^2 + y*G + x
//   write_en    out  write strobe, one voxel per cycle
//   write_data  out  voxel word {30'b0, transparent, solid, rgb[23:0], id[7:0]}
// ---------------------------------------------------------------------------
module voxel_world_gen #(
  parameter int GRID_SIZE = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [17:0] write_addr,
  output logic        write_en,
  output logic [63:0] write_data
);

  localparam int AW = $clog2(GRID_SIZE);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   x_q, y_q, z_q;
  logic [AW-1:0]   x_d, y_d, z_d;
  logic            last_cell;
  logic [17:0]     write_addr_d;
  logic [63:0]     write_data_d;

  // Voxel word for one cell. The terrain height uses the 8-voxel column
  // block indices of x and z, which gives a checkerboard of heights 8..15.
  function automatic logic [63:0] voxel_word(input logic [AW-1:0] x,
                                             input logic [AW-1:0] y,
                                             input logic [AW-1:0] z);
    logic [6:0]  h;
    logic [6:0]  yv;
    logic [7:0]  id;
    logic [23:0] rgb;
    logic        solid;
    logic        transp;
    h      = 7'd8 + 7'(x[AW-1:3] ^ z[AW-1:3]);
    yv     = 7'(y);
    id     = 8'd0;
    rgb    = 24'h000000;
    solid  = 1'b0;
    transp = 1'b0;
    if (yv == 7'd0) begin
      id = 8'd1; rgb = 24'h404040; solid = 1'b1;
    end else if (yv < h - 7'd1) begin
      id = 8'd2; rgb = 24'h808080; solid = 1'b1;
    end else if (yv == h - 7'd1) begin
      id = 8'd3; rgb = 24'h30A030; solid = 1'b1;
    end else if (yv < 7'd10) begin
      // Water fills the gap between the ground surface and the water level.
      id = 8'd4; rgb = 24'h2040C0; transp = 1'b1;
    end
    return {30'd0, transp, solid, rgb, id};
  endfunction

  // Next cell in sweep order: x fastest, then y, then z.
  always_comb begin
    x_d = x_q + 1'b1;
    y_d = y_q;
    z_d = z_q;
    if (&x_q) begin
      y_d = y_q + 1'b1;
      if (&y_q) begin
        z_d = z_q + 1'b1;
      end
    end
  end

  assign last_cell    = (&x_q) & (&y_q) & (&z_q);
  // GRID_SIZE is a power of two, so the linear address is a plain concatenation.
  assign write_addr_d = 18'({z_d, y_d, x_d});
  assign write_data_d = voxel_word(x_d, y_d, z_d);

  // Counters always hold the cell whose write is currently presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          write_en <= 1'b0;
          if (start) begin
            state_q    <= RUN;
            busy       <= 1'b1;
            done       <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            write_en   <= 1'b1;
            write_addr <= '0;
            write_data <= voxel_word('0, '0, '0);
          end
        end
        RUN: begin
          if (last_cell) begin
            state_q  <= IDLE;
            busy     <= 1'b0;
            write_en <= 1'b0;
            done     <= 1'b1;
          end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
            write_en   <= 1'b1;
            write_addr <= write_addr_d;
            write_data <= write_data_d;
          end
        end
        default: begin
          state_q  <= IDLE;
          busy     <= 1'b0;
          write_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voxel_world_gen.sv
// ---------------------------------------------------------------------------
// tb_voxel_world_gen
//   Bench for voxel_world_gen with a 16^3 grid. Every write in each sweep is
//   compared with a reference model computed directly from the terrain rules.
//   A few cells are also compared with literal words. The bench also covers
//   idle after reset, start held or randomly toggled during a sweep, a re-run
//   after done, and an asynchronous reset that aborts a sweep.
// ---------------------------------------------------------------------------
module tb_voxel_world_gen;

  localparam int G = 16;
  localparam int N = G * G * G;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [17:0] write_addr;
  logic        write_en;
  logic [63:0] write_data;

  int n_assert;
  int n_fail;

  logic [63:0] spot_data [6];
  int          spot_addr [6];

  voxel_world_gen #(.GRID_SIZE(G)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .write_addr (write_addr),
    .write_en   (write_en),
    .write_data (write_data)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: material from the terrain rules, then a table lookup.
  function automatic logic [63:0] model_word(input int x, input int y, input int z);
    int h;
    int mat;
    logic [23:0] rgb_tab [5];
    rgb_tab[0] = 24'h000000;
    rgb_tab[1] = 24'h404040;
    rgb_tab[2] = 24'h808080;
    rgb_tab[3] = 24'h30A030;
    rgb_tab[4] = 24'h2040C0;
    h = 8 + ((x / 8) ^ (z / 8));
    if (y == 0)           mat = 1;
    else if (y < h - 1)   mat = 2;
    else if (y == h - 1)  mat = 3;
    else if (y < 10)      mat = 4;
    else                  mat = 0;
    return {30'd0, (mat == 4), (mat >= 1 && mat <= 3), rgb_tab[mat], 8'(mat)};
  endfunction

  // Single comparison point.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Idle checks for a number of cycles, sampled on the falling edge.
  task automatic check_idle(input string tag, input int cycles, input logic exp_done,
                            input logic [17:0] exp_addr, input logic [63:0] exp_data);
    for (int c = 0; c < cycles; c++) begin
      chk({tag, "_busy"}, 64'(busy), 64'(1'b0));
      chk({tag, "_we"},   64'(write_en), 64'(1'b0));
      chk({tag, "_done"}, 64'(done), 64'(exp_done));
      chk({tag, "_addr"}, 64'(write_addr), 64'(exp_addr));
      chk({tag, "_data"}, write_data, exp_data);
      @(negedge clk);
    end
  endtask

  // Driver plus per-cycle scoreboard for one sweep.
  // start_mode: 0 = one-cycle pulse, 1 = held high, 2 = random during sweep.
  // abort_at >= 0 applies reset right after that write index is checked.
  task automatic run_sweep(input string tag, input int start_mode, input int abort_at);
    int x, y, z;
    logic [17:0] exp_q[$];
    for (int i = 0; i < N; i++) exp_q.push_back(18'(i));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      logic [17:0] exp_addr;
      exp_addr = exp_q.pop_front();
      x = i % G;
      y = (i / G) % G;
      z = i / (G * G);
      case (start_mode)
        0:       start = 1'b0;
        1:       start = 1'b1;
        default: start = 1'($urandom_range(0, 1));
      endcase
      chk($sformatf("%s_we[%0d]", tag, i),   64'(write_en), 64'(1'b1));
      chk($sformatf("%s_busy[%0d]", tag, i), 64'(busy), 64'(1'b1));
      chk($sformatf("%s_done[%0d]", tag, i), 64'(done), 64'(1'b0));
      chk($sformatf("%s_addr[%0d]", tag, i), 64'(write_addr), 64'(exp_addr));
      chk($sformatf("%s_data[%0d]", tag, i), write_data, model_word(x, y, z));
      for (int k = 0; k < 6; k++) begin
        if (spot_addr[k] == i) spot_data[k] = write_data;
      end
      if (i == abort_at) begin
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_rst_busy"}, 64'(busy), 64'(1'b0));
        chk({tag, "_rst_done"}, 64'(done), 64'(1'b0));
        chk({tag, "_rst_we"},   64'(write_en), 64'(1'b0));
        chk({tag, "_rst_addr"}, 64'(write_addr), 64'(18'd0));
        chk({tag, "_rst_data"}, write_data, 64'd0);
        return;
      end
      @(negedge clk);
    end
    // Cycle after the final write: back in idle with done set.
    start = 1'b0;
    chk({tag, "_fin_busy"}, 64'(busy), 64'(1'b0));
    chk({tag, "_fin_we"},   64'(write_en), 64'(1'b0));
    chk({tag, "_fin_done"}, 64'(done), 64'(1'b1));
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    spot_addr[0] = 0;   // (0,0,0)  bedrock
    spot_addr[1] = 112; // (0,7,0)  grass
    spot_addr[2] = 128; // (0,8,0)  water
    spot_addr[3] = 160; // (0,10,0) air
    spot_addr[4] = 136; // (8,8,0)  grass, raised column h=9
    spot_addr[5] = 39;  // (7,2,0)  stone
    for (int k = 0; k < 6; k++) spot_data[k] = 'x;

    rst_n = 1'b0;
    start = 1'b0;
    #23;
    chk("reset_busy", 64'(busy), 64'(1'b0));
    chk("reset_done", 64'(done), 64'(1'b0));
    chk("reset_we",   64'(write_en), 64'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("idle0", 10, 1'b0, 18'd0, 64'd0);

    // Sweep 1: single start pulse.
    run_sweep("sw1", 0, -1);
    chk("spot_000",  spot_data[0], 64'h0000_0001_4040_4001);
    chk("spot_070",  spot_data[1], 64'h0000_0001_30A0_3003);
    chk("spot_080",  spot_data[2], 64'h0000_0002_2040_C004);
    chk("spot_0a0",  spot_data[3], 64'h0000_0000_0000_0000);
    chk("spot_880",  spot_data[4], 64'h0000_0001_30A0_3003);
    chk("spot_720",  spot_data[5], 64'h0000_0001_8080_8002);
    @(negedge clk);
    check_idle("done1", 100, 1'b1, 18'(N - 1), model_word(G - 1, G - 1, G - 1));

    // Sweep 2: start held high throughout; no restart, no stretch.
    run_sweep("sw2", 1, -1);
    @(negedge clk);
    check_idle("done2", 20, 1'b1, 18'(N - 1), model_word(G - 1, G - 1, G - 1));

    // Sweep 3: random start activity while busy, then abort with reset.
    run_sweep("sw3", 2, 1000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst", 20, 1'b0, 18'd0, 64'd0);

    // Sweep 4: recovery after the aborted run, random start while busy.
    run_sweep("sw4", 2, -1);
    @(negedge clk);
    check_idle("done4", 10, 1'b1, 18'(N - 1), model_word(G - 1, G - 1, G - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
